// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its decoder-facing bus.
`ifndef ID_IN_MSB
`define ID_IN_MSB 14
`endif

package instruction_fetch_unit_pkg;

  localparam int ID_IN_MSB = `ID_IN_MSB;
  localparam int INS_W_DEF = ID_IN_MSB + 1;
  localparam int OPC_W     = 5;

  // Unused slot in the REST opcode section, repurposed as end-of-program marker
  localparam logic [OPC_W-1:0] OPCODE_HLT = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    FETCH,
    RUN,
    HALT
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] opcodeOf(input logic [INS_W_DEF-1:0] ins);
    return ins[INS_W_DEF-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Loader stream plus decoder-side instruction bus of the fetch unit.
interface instruction_fetch_unit_if #(
  parameter int INS_W = 15,
  parameter int PC_W  = 8
);

  logic             load_en;
  logic             ld_valid;
  logic [7:0]       ld_data;
  logic             ld_ready;
  logic             load_done;
  logic             run;
  logic [INS_W-1:0] Ins;
  logic             Ins_valid;
  logic [PC_W-1:0]  PC;
  logic             halted;

  modport master (
    input  load_en, ld_valid, ld_data, run,
    output ld_ready, load_done, Ins, Ins_valid, PC, halted
  );

  modport slave (
    output load_en, ld_valid, ld_data, run,
    input  ld_ready, load_done, Ins, Ins_valid, PC, halted
  );

endinterface

// File: rtl/instruction_fetch_unit_program_memory.sv
// Program store: one write port and one synchronous read port (1-cycle latency).
module program_memory #(
  parameter int INS_W    = 15,
  parameter int PM_DEPTH = 256,
  parameter int PC_W     = $clog2(PM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PC_W-1:0]  i_waddr,
  input  logic [INS_W-1:0] i_wdata,
  input  logic             i_re,
  input  logic [PC_W-1:0]  i_raddr,
  output logic [INS_W-1:0] o_rdata
);

  logic [INS_W-1:0] r_mem [PM_DEPTH];
  logic [INS_W-1:0] r_rdata;

  // Contents survive reset on purpose, so no reset branch here
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loads a program from a byte stream, then feeds the
// decoder one instruction word per cycle until HLT or end of program.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int INS_W    = INS_W_DEF,
  parameter int PM_DEPTH = 256,
  parameter int PC_W     = $clog2(PM_DEPTH)
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  instruction_fetch_unit_if.master io_bus
);

  // One extra bit so counters can hold PM_DEPTH itself
  localparam int              CNT_W   = PC_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PM_DEPTH);

  fetch_state_t     r_state, w_stateNext;
  logic [CNT_W-1:0] r_pc, w_pcNext;
  logic [CNT_W-1:0] r_wrPtr, w_wrPtrNext;
  logic [CNT_W-1:0] r_progLen, w_progLenNext;
  logic [6:0]       r_hiByte, w_hiByteNext;
  logic [INS_W-1:0] r_ins, w_insNext;
  logic             r_insValid, w_insValidNext;
  logic             r_loadDone, w_loadDoneNext;
  logic             r_ldBlock, w_ldBlockNext;

  logic             w_ldReady;
  logic             w_hs;
  logic             w_atEnd;
  logic             w_isHlt;
  logic             w_lastWrite;
  logic             w_loadStart;
  logic [CNT_W-1:0] w_pcInc;
  logic             w_memWe;
  logic             w_memRe;
  logic [PC_W-1:0]  w_memRaddr;
  logic [INS_W-1:0] w_memWdata;
  logic [INS_W-1:0] w_memRdata;

  program_memory #(
    .INS_W    (INS_W),
    .PM_DEPTH (PM_DEPTH),
    .PC_W     (PC_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_memWe && i_rst_n),
    .i_waddr (r_wrPtr[PC_W-1:0]),
    .i_wdata (w_memWdata),
    .i_re    (w_memRe),
    .i_raddr (w_memRaddr),
    .o_rdata (w_memRdata)
  );

  assign w_ldReady   = ((r_state == LOAD_HI) || (r_state == LOAD_LO)) && io_bus.load_en;
  assign w_hs        = io_bus.ld_valid && w_ldReady;
  assign w_atEnd     = (r_pc >= r_progLen);
  assign w_isHlt     = (opcodeOf(w_memRdata) == OPCODE_HLT);
  assign w_lastWrite = (r_wrPtr == DEPTH_C - 1'b1);
  assign w_pcInc     = r_pc + 1'b1;
  assign w_memWdata  = {r_hiByte, io_bus.ld_data};
  // A full load blocks re-entry until load_en is released, so surplus bytes are refused
  assign w_loadStart = io_bus.load_en && !r_ldBlock;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_wrPtr    <= '0;
      r_progLen  <= '0;
      r_hiByte   <= '0;
      r_ins      <= '0;
      r_insValid <= 1'b0;
      r_loadDone <= 1'b0;
      r_ldBlock  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_pc       <= w_pcNext;
      r_wrPtr    <= w_wrPtrNext;
      r_progLen  <= w_progLenNext;
      r_hiByte   <= w_hiByteNext;
      r_ins      <= w_insNext;
      r_insValid <= w_insValidNext;
      r_loadDone <= w_loadDoneNext;
      r_ldBlock  <= w_ldBlockNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_loadStart)     w_stateNext = LOAD_HI;
        else if (io_bus.run) w_stateNext = FETCH;
      end
      LOAD_HI: begin
        if (!io_bus.load_en) w_stateNext = IDLE;
        else if (w_hs)       w_stateNext = LOAD_LO;
      end
      LOAD_LO: begin
        if (!io_bus.load_en) w_stateNext = IDLE;
        else if (w_hs)       w_stateNext = w_lastWrite ? IDLE : LOAD_HI;
      end
      FETCH: begin
        w_stateNext = w_atEnd ? HALT : RUN;
      end
      RUN: begin
        if (w_atEnd)          w_stateNext = HALT;
        else if (!io_bus.run) w_stateNext = IDLE;
        else if (w_isHlt)     w_stateNext = HALT;
      end
      HALT: begin
        if (w_loadStart)      w_stateNext = LOAD_HI;
        else if (!io_bus.run) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_pcNext       = r_pc;
    w_wrPtrNext    = r_wrPtr;
    w_progLenNext  = r_progLen;
    w_hiByteNext   = r_hiByte;
    w_insNext      = r_ins;
    w_insValidNext = 1'b0;
    w_loadDoneNext = 1'b0;
    w_ldBlockNext  = r_ldBlock && io_bus.load_en;
    w_memWe        = 1'b0;
    w_memRe        = (r_state == FETCH) || (r_state == RUN);
    w_memRaddr     = r_pc[PC_W-1:0];
    unique case (r_state)
      IDLE: begin
        if (w_loadStart) w_wrPtrNext = '0;
      end
      LOAD_HI: begin
        if (!io_bus.load_en) begin
          w_progLenNext  = r_wrPtr;
          w_pcNext       = '0;
          w_loadDoneNext = 1'b1;
        end else if (w_hs) begin
          w_hiByteNext = io_bus.ld_data[6:0];
        end
      end
      LOAD_LO: begin
        // Dropping load_en here discards the pending hi byte
        if (!io_bus.load_en) begin
          w_progLenNext  = r_wrPtr;
          w_pcNext       = '0;
          w_loadDoneNext = 1'b1;
        end else if (w_hs) begin
          w_memWe     = 1'b1;
          w_wrPtrNext = r_wrPtr + 1'b1;
          if (w_lastWrite) begin
            w_progLenNext  = DEPTH_C;
            w_pcNext       = '0;
            w_loadDoneNext = 1'b1;
            w_ldBlockNext  = 1'b1;
          end
        end
      end
      RUN: begin
        // Read data always corresponds to mem[PC]; prefetch PC+1 only when PC advances
        if (!w_atEnd && io_bus.run && !w_isHlt) begin
          w_insNext      = w_memRdata;
          w_insValidNext = 1'b1;
          w_pcNext       = w_pcInc;
          w_memRaddr     = w_pcInc[PC_W-1:0];
        end
      end
      HALT: begin
        if (w_loadStart)      w_wrPtrNext = '0;
        else if (!io_bus.run) w_pcNext    = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    io_bus.ld_ready  = w_ldReady;
    io_bus.load_done = r_loadDone;
    io_bus.Ins       = r_ins;
    io_bus.Ins_valid = r_insValid;
    io_bus.PC        = r_pc[PC_W-1:0];
    io_bus.halted    = (r_state == HALT);
  end

endmodule
